// File: rtl/mux_display_capture.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment bus: filters the
// scanned digits, reassembles 28-bit frames and classifies frame-to-frame changes.
module mux_display_capture #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 21
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  AN,
  input  logic [6:0]  DISP,
  output logic [27:0] FRAME,
  output logic        FRAME_VALID,
  output logic        CHANGED,
  output logic        SCROLL_FWD,
  output logic        SCROLL_BWD,
  output logic        SEQ_ERR,
  output logic        MULTI_ERR,
  output logic        STALE
);

  localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  logic [3:0]       an_s1, an_s2;
  logic [6:0]       disp_s1, disp_s2;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             bus_chg;
  logic             acc;
  logic [1:0]       acc_idx;
  logic             an_valid;
  logic             an_blank;
  logic             digit_acc;
  logic             blank_acc;
  logic             multi_acc;
  logic             to_hit;

  state_t           state;
  logic [1:0]       exp_idx;
  logic [27:0]      shadow;
  logic             pending;
  logic             have_prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      an_s1   <= '1;
      an_s2   <= '1;
      disp_s1 <= '1;
      disp_s2 <= '1;
    end else begin
      an_s1   <= AN;
      an_s2   <= an_s1;
      disp_s1 <= DISP;
      disp_s2 <= disp_s1;
    end
  end

  // The filter watches the second flop; a pending difference in the first flop
  // means the value held in the second is about to change.
  assign bus_chg = {an_s1, disp_s1} != {an_s2, disp_s2};

  always_ff @(posedge CLK) begin
    if (RST) begin
      settle_cnt <= '0;
    end else if (bus_chg) begin
      settle_cnt <= '0;
    end else if (settle_cnt != SETTLE_MAX) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign acc = !bus_chg && (settle_cnt == SETTLE_LAST);

  always_comb begin
    acc_idx  = 2'd0;
    an_valid = 1'b0;
    an_blank = 1'b0;
    case (an_s2)
      4'b0111: begin acc_idx = 2'd0; an_valid = 1'b1; end
      4'b1011: begin acc_idx = 2'd1; an_valid = 1'b1; end
      4'b1101: begin acc_idx = 2'd2; an_valid = 1'b1; end
      4'b1110: begin acc_idx = 2'd3; an_valid = 1'b1; end
      4'b1111: an_blank = 1'b1;
      default: ;
    endcase
  end

  assign digit_acc = acc && an_valid;
  assign blank_acc = acc && an_blank;
  assign multi_acc = acc && !an_valid && !an_blank;

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt <= '0;
    end else if (digit_acc || blank_acc) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = !(digit_acc || blank_acc) && (to_cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= HUNT;
      exp_idx     <= '0;
      shadow      <= '1;
      pending     <= 1'b0;
      have_prev   <= 1'b0;
      FRAME       <= '1;
      FRAME_VALID <= 1'b0;
      CHANGED     <= 1'b0;
      SCROLL_FWD  <= 1'b0;
      SCROLL_BWD  <= 1'b0;
      SEQ_ERR     <= 1'b0;
      MULTI_ERR   <= 1'b0;
      STALE       <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      CHANGED     <= 1'b0;
      SCROLL_FWD  <= 1'b0;
      SCROLL_BWD  <= 1'b0;
      SEQ_ERR     <= 1'b0;
      if (multi_acc) begin
        MULTI_ERR <= 1'b1;
      end
      if (to_hit) begin
        STALE     <= 1'b1;
        state     <= HUNT;
        exp_idx   <= '0;
        pending   <= 1'b0;
        have_prev <= 1'b0;
      end else begin
        // Frame commit happens one cycle after the last digit lands in the shadow.
        if (pending) begin
          pending     <= 1'b0;
          FRAME       <= shadow;
          FRAME_VALID <= 1'b1;
          have_prev   <= 1'b1;
          if (have_prev && (shadow != FRAME)) begin
            CHANGED <= 1'b1;
            if (shadow[20:0] == FRAME[27:7]) begin
              SCROLL_FWD <= 1'b1;
            end else if (shadow[27:7] == FRAME[20:0]) begin
              SCROLL_BWD <= 1'b1;
            end
          end
        end
        if (digit_acc) begin
          if (acc_idx == 2'd0) begin
            STALE <= 1'b0;
          end
          case (state)
            HUNT: begin
              if (acc_idx == 2'd0) begin
                shadow[6:0] <= disp_s2;
                exp_idx     <= 2'd1;
                state       <= COLLECT;
              end
            end
            COLLECT: begin
              if (acc_idx == exp_idx) begin
                shadow[7*int'(acc_idx) +: 7] <= disp_s2;
                exp_idx <= exp_idx + 2'd1;
                if (exp_idx == 2'd3) begin
                  pending <= 1'b1;
                end
              end else begin
                SEQ_ERR <= 1'b1;
                if (acc_idx == 2'd0) begin
                  shadow[6:0] <= disp_s2;
                  exp_idx     <= 2'd1;
                end else begin
                  exp_idx <= '0;
                  state   <= HUNT;
                end
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule
